// File: rtl/hfg_feature_sum_19x19_if.sv
// Handshake bundle between the 19x19 Haar controller, IIBG read data
// and the feature-sum stage that writes the FBR.
interface hfg_feature_sum_19x19_if #(
    parameter int DATA_W = 17,
    parameter int ADDR_W = 7
);
    logic                     iRun;
    logic                     iRdreq;
    logic [DATA_W-1:0]        iData;
    logic [7:0]               iSign;
    logic                     iFull;
    logic                     oReady;
    logic                     oWrreq_FBR;
    logic [ADDR_W-1:0]        oAddr_FBR;
    logic signed [DATA_W+3:0] oData_FBR;
    logic                     oDone;
    logic                     oErr;

    modport master (
        output iRun,
        output iRdreq,
        output iData,
        output iSign,
        output iFull,
        input  oReady,
        input  oWrreq_FBR,
        input  oAddr_FBR,
        input  oData_FBR,
        input  oDone,
        input  oErr
    );

    modport slave (
        input  iRun,
        input  iRdreq,
        input  iData,
        input  iSign,
        input  iFull,
        output oReady,
        output oWrreq_FBR,
        output oAddr_FBR,
        output oData_FBR,
        output oDone,
        output oErr
    );
endinterface

// File: rtl/hfg_feature_sum_19x19.sv
// Collects up to 8 integral-image corners per feature, forms the signed
// corner sum one term per cycle and writes it to the feature result buffer.
module hfg_feature_sum_19x19 #(
    parameter int DATA_W       = 17,
    parameter int RD_LAT       = 2,
    parameter int NUM_FEATURES = 115,
    parameter int ADDR_W       = 7
) (
    input logic                    iClk,
    input logic                    iReset,
    hfg_feature_sum_19x19_if.slave bus
);

    localparam int SUM_W = DATA_W + 4;

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] DRAIN   = 2'd1;
    localparam logic [1:0] SUM     = 2'd2;
    localparam logic [1:0] WRITE   = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_FEATURES - 1);

    logic [1:0]              state;
    logic [RD_LAT-1:0]       pipe;
    logic                    dvalid;
    logic [3:0]              cnt;
    logic [DATA_W-1:0]       corner [0:7];
    logic [7:0]              sgn;
    logic [2:0]              idx;
    logic signed [SUM_W-1:0] acc;
    logic signed [SUM_W-1:0] acc_next;
    logic signed [SUM_W-1:0] term;
    logic [ADDR_W-1:0]       addr;

    logic                    clr;
    logic                    busy;
    logic                    accept_rd;
    logic                    store;

    logic                    wr_q;
    logic                    ready_q;
    logic                    done_q;
    logic                    err_q;
    logic [ADDR_W-1:0]       addr_q;
    logic signed [SUM_W-1:0] data_q;

    assign clr       = iReset | ~bus.iRun;
    assign busy      = (state == SUM) || (state == WRITE);
    assign accept_rd = bus.iRdreq & ~busy;
    assign dvalid    = pipe[RD_LAT-1];
    assign store     = dvalid && !busy && (cnt < 4'd8);

    // Corners are zero-extended; terms past the captured count add nothing.
    always_comb begin
        term     = {4'b0000, corner[idx]};
        acc_next = acc;
        if ({1'b0, idx} < cnt) begin
            acc_next = sgn[idx] ? (acc - term) : (acc + term);
        end
    end

    always_ff @(posedge iClk) begin
        if (store) begin
            corner[cnt[2:0]] <= bus.iData;
        end
    end

    always_ff @(posedge iClk) begin
        if (clr) begin
            state   <= COLLECT;
            pipe    <= '0;
            cnt     <= '0;
            sgn     <= '0;
            idx     <= '0;
            acc     <= '0;
            addr    <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            pipe[0] <= accept_rd;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end

            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;

            if (busy && (bus.iRdreq || bus.iFull)) begin
                err_q <= 1'b1;
            end

            if (dvalid && !busy) begin
                if (cnt == 4'd8) begin
                    err_q <= 1'b1;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end

            unique case (1'b1)
                state == COLLECT: begin
                    if (bus.iFull) begin
                        sgn   <= bus.iSign;
                        state <= DRAIN;
                    end
                end
                // A request arriving on the exit cycle would lose its data.
                state == DRAIN: begin
                    if (pipe == '0 && !bus.iRdreq) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= SUM;
                    end
                end
                state == SUM: begin
                    acc <= acc_next;
                    idx <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        state   <= WRITE;
                        wr_q    <= 1'b1;
                        ready_q <= 1'b1;
                        done_q  <= (addr == LAST_ADDR);
                        addr_q  <= addr;
                        data_q  <= acc_next;
                    end
                end
                state == WRITE: begin
                    cnt   <= '0;
                    addr  <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                    state <= COLLECT;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    assign bus.oReady     = ready_q;
    assign bus.oWrreq_FBR = wr_q;
    assign bus.oAddr_FBR  = addr_q;
    assign bus.oData_FBR  = data_q;
    assign bus.oDone      = done_q;
    assign bus.oErr       = err_q;

endmodule

// File: tb/tb_hfg_feature_sum_19x19.sv
// Directed bench for hfg_feature_sum_19x19 with a group-level reference
// model and a per-cycle output checker.
module tb_hfg_feature_sum_19x19;

    localparam int DATA_W = 17;
    localparam int RD_LAT = 2;
    localparam int NF     = 115;
    localparam int ADDR_W = 7;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    hfg_feature_sum_19x19_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut_if ();

    hfg_feature_sum_19x19 #(
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT),
        .NUM_FEATURES(NF),
        .ADDR_W(ADDR_W)
    ) dut (
        .iClk(clk),
        .iReset(rst),
        .bus(dut_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // IIBG stand-in: returns the value presented with a request RD_LAT later
    logic [DATA_W-1:0] rd_value;
    logic [DATA_W-1:0] ret [RD_LAT];
    always @(posedge clk) begin
        ret[0] <= rd_value;
        for (int k = 1; k < RD_LAT; k++) ret[k] <= ret[k-1];
    end
    assign dut_if.iData = ret[RD_LAT-1];

    typedef struct {
        int     addr;
        longint data;
        bit     done;
        bit     err;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   cur;
    int     vals[16];
    int     m_addr;
    bit     m_err;
    int     hold_addr;
    longint hold_data;
    bit     mon_en = 1'b0;
    int     n_cmp = 0;
    int     n_fail = 0;
    int     wr_cnt = 0;
    int     wr_cyc = 0;
    int     done_cnt = 0;
    logic signed [63:0] dut_data;
    int     dut_addr;
    int     lat;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (dut_if.oDone === 1'b1) done_cnt++;
            if (dut_if.oWrreq_FBR === 1'b1) begin
                wr_cnt++;
                wr_cyc   = cyc;
                dut_data = dut_if.oData_FBR;
                dut_addr = int'(dut_if.oAddr_FBR);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %0d required no write",
                             dut_addr, dut_data);
                end else begin
                    cur = exp_q.pop_front();
                    chk("wr_addr", dut_if.oAddr_FBR, cur.addr);
                    chk("wr_data", dut_if.oData_FBR, cur.data);
                    chk("wr_done", dut_if.oDone, cur.done);
                    chk("wr_ready", dut_if.oReady, 1);
                    chk("wr_err", dut_if.oErr, cur.err);
                    hold_addr = cur.addr;
                    hold_data = cur.data;
                end
            end else begin
                chk("idle_wrreq", dut_if.oWrreq_FBR, 0);
                chk("idle_ready", dut_if.oReady, 0);
                chk("idle_done", dut_if.oDone, 0);
                chk("hold_addr", dut_if.oAddr_FBR, hold_addr);
                chk("hold_data", dut_if.oData_FBR, hold_data);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        m_addr    = 0;
        m_err     = 1'b0;
        hold_addr = 0;
        hold_data = 0;
        exp_q.delete();
    endtask

    // Group result: signed sum of the first eight returned corners.
    task automatic push_expect(input int n, input logic [7:0] sign);
        longint s = 0;
        exp_t   e;
        if (n > 8) m_err = 1'b1;
        for (int i = 0; i < n && i < 8; i++) begin
            s += sign[i] ? -longint'(vals[i]) : longint'(vals[i]);
        end
        e.addr = m_addr;
        e.data = s;
        e.done = (m_addr == NF - 1);
        e.err  = m_err;
        exp_q.push_back(e);
        m_addr = (m_addr + 1) % NF;
    endtask

    task automatic wait_write(input int start, input int budget);
        int k = 0;
        while (wr_cnt == start && k < budget) begin
            step;
            k++;
        end
        if (wr_cnt == start) begin
            n_cmp++;
            n_fail++;
            $display("FAIL write_timeout: got no write in %0d cycles required one",
                     budget);
        end
    endtask

    task automatic run_group(input int n, input logic [7:0] sign,
                             input bit full_last, input bit poke,
                             output int latency);
        int start;
        int full_cyc;
        start    = wr_cnt;
        full_cyc = cyc;
        push_expect(n, sign);
        for (int i = 0; i < n; i++) begin
            dut_if.iRdreq = 1'b1;
            rd_value      = DATA_W'(vals[i]);
            dut_if.iSign  = sign;
            if (full_last && i == n - 1) begin
                dut_if.iFull = 1'b1;
                full_cyc     = cyc;
            end
            step;
        end
        dut_if.iRdreq = 1'b0;
        dut_if.iFull  = 1'b0;
        if (!(full_last && n > 0)) begin
            repeat (RD_LAT + 1) step;
            dut_if.iFull = 1'b1;
            dut_if.iSign = sign;
            full_cyc     = cyc;
            step;
            dut_if.iFull = 1'b0;
        end
        if (poke) begin
            while (cyc < full_cyc + 5) step;
            dut_if.iRdreq = 1'b1;
            step;
            dut_if.iRdreq = 1'b0;
        end
        wait_write(start, 40);
        latency = wr_cyc - full_cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int full_cyc;
        rst           = 1'b1;
        dut_if.iRun   = 1'b1;
        dut_if.iRdreq = 1'b0;
        dut_if.iFull  = 1'b0;
        dut_if.iSign  = 8'h00;
        rd_value      = '0;
        repeat (3) step;
        rst = 1'b0;
        model_clear();
        mon_en = 1'b1;

        chk("rst_wrreq", dut_if.oWrreq_FBR, 0);
        chk("rst_ready", dut_if.oReady, 0);
        chk("rst_done", dut_if.oDone, 0);
        chk("rst_err", dut_if.oErr, 0);
        chk("rst_addr", dut_if.oAddr_FBR, 0);
        chk("rst_data", dut_if.oData_FBR, 0);
        repeat (2) step;

        for (int i = 0; i < 8; i++) vals[i] = 10 * (i + 1);
        run_group(8, 8'hAA, 1'b0, 1'b0, lat);
        chk("t1_latency", lat, 10);
        chk("t1_data", dut_data, -40);
        chk("t1_addr", dut_addr, 0);

        vals[0] = 100; vals[1] = 5; vals[2] = 5; vals[3] = 100;
        run_group(4, 8'h06, 1'b1, 1'b0, lat);
        chk("t2_latency", lat, 12);
        chk("t2_data", dut_data, 190);
        chk("t2_addr", dut_addr, 1);

        dut_if.iRun = 1'b0;
        step;
        dut_if.iRun = 1'b1;
        model_clear();
        done_cnt = 0;

        for (int k = 0; k <= NF; k++) begin
            vals[0] = (k < NF) ? k : 7;
            run_group(1, 8'h00, 1'b1, 1'b0, lat);
            if (k == 0) chk("t3_latency", lat, 12);
            if (k == NF - 1) chk("t3_last_addr", dut_addr, NF - 1);
        end
        chk("t3_wrap_addr", dut_addr, 0);
        chk("t3_wrap_data", dut_data, 7);
        chk("t3_done_count", done_cnt, 1);

        for (int i = 0; i < 8; i++) vals[i] = (1 << DATA_W) - 1;
        run_group(8, 8'hFF, 1'b0, 1'b0, lat);
        chk("t4_neg_max", dut_data, -1048568);
        run_group(8, 8'h00, 1'b0, 1'b0, lat);
        chk("t4_pos_max", dut_data, 1048568);

        start = wr_cnt;
        vals[0] = 3; vals[1] = 4;
        for (int i = 0; i < 2; i++) begin
            dut_if.iRdreq = 1'b1;
            rd_value      = DATA_W'(vals[i]);
            step;
        end
        dut_if.iRdreq = 1'b0;
        repeat (RD_LAT + 1) step;
        dut_if.iFull = 1'b1;
        full_cyc     = cyc;
        step;
        dut_if.iFull = 1'b0;
        while (cyc < full_cyc + 5) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        model_clear();
        repeat (15) step;
        chk("t6_no_write", wr_cnt, start);
        chk("t6_wrreq", dut_if.oWrreq_FBR, 0);
        chk("t6_addr", dut_if.oAddr_FBR, 0);
        chk("t6_data", dut_if.oData_FBR, 0);
        vals[0] = 9;
        run_group(1, 8'h00, 1'b1, 1'b0, lat);
        chk("t6_next_addr", dut_addr, 0);
        chk("t6_next_data", dut_data, 9);

        vals[0] = 3; vals[1] = 4; vals[2] = 5;
        m_err = 1'b1;
        run_group(3, 8'h00, 1'b0, 1'b1, lat);
        chk("t5_poke_data", dut_data, 12);
        chk("t5_err_set", dut_if.oErr, 1);
        for (int i = 0; i < 9; i++) vals[i] = i + 1;
        run_group(9, 8'h0F, 1'b0, 1'b0, lat);
        chk("t5_nine_data", dut_data, 16);
        chk("t5_err_sticky", dut_if.oErr, 1);
        dut_if.iRun = 1'b0;
        step;
        dut_if.iRun = 1'b1;
        model_clear();
        chk("t5_err_clear", dut_if.oErr, 0);
        chk("t5_clr_addr", dut_if.oAddr_FBR, 0);

        run_group(0, 8'hFF, 1'b0, 1'b0, lat);
        chk("empty_latency", lat, 10);
        chk("empty_data", dut_data, 0);
        chk("empty_addr", dut_addr, 0);

        repeat (3) step;
        chk("exp_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_fail);
        $finish;
    end

endmodule

// File: doc/hfg_feature_sum_19x19.md
Name: hfg_feature_sum_19x19

Overview:
- Downstream consumer of the 19x19 Haar feature-generator controller.
- Captures the integral-image corner values that the controller's read requests return from the integral image buffer (IIBG), one group of up to 8 corners per feature.
- On the controller's group-end strobe, forms the signed corner sum using the controller's per-corner sign vector and writes it into the feature result buffer (FBR).
- Hands `oReady` back to the controller and flags completion of a full feature set.

Parameters:
- DATA_W, 17, width of one unsigned integral-image word (361*255 < 2^17).
- RD_LAT, 2, IIBG read latency in cycles from `iRdreq` to data valid (legal range 1..4).
- NUM_FEATURES, 115, number of features per window; FBR address wraps after NUM_FEATURES-1.
- ADDR_W, 7, FBR address width.

Ports:
- iClk  in  1  clock.
- iReset  in  1  synchronous active-high reset.
- iRun  in  1  window run enable; low acts as a synchronous clear, identical to reset.
- iRdreq  in  1  controller read request to IIBG; data returns RD_LAT cycles later.
- iData  in  DATA_W  IIBG read data.
- iSign  in  8  per-corner sign, bit i for corner i (1 = subtract, 0 = add); valid in the cycle `iFull` is high.
- iFull  in  1  one-cycle pulse: all reads for the current group have been issued.
- oReady  out  1  one-cycle pulse: group consumed, controller may issue the next group.
- oWrreq_FBR  out  1  FBR write strobe, one cycle.
- oAddr_FBR  out  ADDR_W  FBR write address.
- oData_FBR  out  DATA_W+4  signed two's-complement feature sum.
- oDone  out  1  one-cycle pulse coincident with the write to address NUM_FEATURES-1.
- oErr  out  1  sticky protocol-error flag.

Behaviour:
- Reset, or `iRun` low: synchronous clear of all state.
  - State = COLLECT, corner count = 0, valid pipe cleared, accumulator = 0.
  - All outputs low/zero: `oReady`=0, `oWrreq_FBR`=0, `oAddr_FBR`=0, `oData_FBR`=0, `oDone`=0, `oErr`=0.
  - Any in-flight reads are discarded.
- Valid pipe: RD_LAT-deep shift register of `iRdreq`; its tail is `dvalid`. In-flight reads exist while any pipe bit is 1.
- COLLECT:
  - On `dvalid`, store `iData` into buf[cnt] and increment cnt.
  - A 9th `dvalid` in one group is dropped and sets `oErr`.
  - On `iFull`: latch `iSign` into sgn, go to DRAIN. A `dvalid` in the same cycle is still captured.
- DRAIN:
  - Keep capturing `dvalid` exactly as in COLLECT.
  - When the pipe is all zero, clear acc and i, then go to SUM.
- SUM, one term per cycle for i = 0..7:
  - If i < cnt: acc <= acc - buf[i] when sgn[i]=1, else acc + buf[i].
  - Terms with i >= cnt are skipped.
  - buf is zero-extended to DATA_W+4 and acc is signed. No overflow is possible with 8 terms.
  - After i=7, go to WRITE. SUM always takes 8 cycles.
- WRITE, single cycle:
  - Drive `oWrreq_FBR`=1, `oData_FBR`=acc, `oAddr_FBR`=current address.
  - `oDone`=1 if the address equals NUM_FEATURES-1.
  - `oReady`=1. cnt<=0. Go to COLLECT.
  - Address advances in the next cycle, wrapping NUM_FEATURES-1 -> 0.
- `oData_FBR` and `oAddr_FBR` hold their values between writes.
- Latency: from the pipe draining to `oWrreq_FBR` is 9 cycles (1 DRAIN exit + 8 SUM). With all reads complete when `iFull` arrives, `iFull` -> `oWrreq_FBR` is 10 cycles.
- Protocol errors: `iRdreq` or `iFull` while in SUM or WRITE.
  - The request is ignored and `oErr` is set.
  - `oErr` clears only on reset or `iRun` low.
- An empty group (`iFull` with cnt=0 and no reads in flight) is legal and writes 0.

Test Plan:
- Reset, RD_LAT=2:
  - 8 reads returning 10,20,...,80, then `iFull` with `iSign`=8'b1010_1010.
  - Expect: after 10 cycles, one write, addr 0, data 10-20+30-40+50-60+70-80 = -40, and an `oReady` pulse.
- 4 reads 100,5,5,100 with `iSign`=8'b0000_0110, `iFull` in the same cycle as the 4th `iRdreq`.
  - Expect: DRAIN waits 2 cycles, then data 190.
- 115 back-to-back groups, each 1 read of value k (k = 0..114), `iSign`=0.
  - Expect: writes to addr 0..114 with data k, `oDone` only at addr 114, 116th group writes addr 0.
- All inputs at max: 8 reads of 2^17-1 with `iSign`=8'hFF.
  - Expect: data -1048568 with no wrap. Repeat with `iSign`=0, expect +1048568.
- Errors: `iRdreq` pulsed during SUM, and a group with 9 reads.
  - Expect: `oErr`=1 sticky, the group result uses only the first 8 values, and `oErr` is cleared by `iRun`=0.
- Mid-operation clear: assert `iReset` in the 4th SUM cycle.
  - Expect: no write, all outputs zero, next group written at addr 0.
